regfile_32x64: RTL and testbench
================================

// Module: regfile_32x64
// PURPOSE
//   32-entry x 64-bit general-purpose register file for the pipelined LEGv8 CPU (ID stage).
//   One synchronous write port and two combinational read ports.
//   Each read port is a mux64x32_1 driven by the 32 stored words.
//   X31 is XZR (reads 0, writes ignored). ReadData1/2 feed the ID-stage forwarding muxes (mux64x4_1).
// PARAMETERS
//   DATA_W     64   word width; fixed to match mux64x32_1
//   NUM_REGS   32   register count; fixed to match 5-bit select
//   ZERO_REG   31   index hardwired to zero
// PORTS
//   clk            in   1    system clock; all state updates on posedge
//   reset          in   1    synchronous, active-high reset
//   RegWrite       in   1    write enable for this cycle
//   WriteRegister  in   5    destination register index
//   WriteData      in   64   data to write
//   ReadRegister1  in   5    read port 1 index (Rn)
//   ReadRegister2  in   5    read port 2 index (Rm/Rd)
//   ReadData1      out  64   contents of ReadRegister1
//   ReadData2      out  64   contents of ReadRegister2
// BEHAVIOUR
//   - Storage: 31 x 64 D flip-flops (X0..X30). Write-enable decode is a 5:32 decoder gated by RegWrite.
//     Decoder output 31 is unused.
//   - Write: at posedge clk, if RegWrite=1 and WriteRegister!=31, regs[WriteRegister] <= WriteData.
//     Only one register changes per edge.
//   - XZR: regs[31] is a constant 0 word, not a flop.
//     A write to index 31 is a no-op; a read of 31 returns 64'h0 at all times.
//   - Reset: at posedge clk with reset=1, all X0..X30 go to 0. Reset takes priority over a
//     simultaneous write. Reset mid-operation discards the pending write. From the next cycle,
//     ReadData1 = ReadData2 = 64'h0 for every index.
//   - Read: purely combinational, zero latency. Path is index -> mux64x32_1 -> ReadData.
//     Both ports are independent and may read the same index.
//   - Before the first reset, register contents are X. The bench must assert reset for at least one edge.
//   - Read/write same index, same cycle: behaviour depends on REGFILE_BYPASS_EN (below).
//   - No stall/enable input. The writeback stage withholds RegWrite when the instruction is squashed.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Each read port has a write-through bypass (mux64x2_1). When RegWrite=1,
//       WriteRegister==ReadRegisterN, and WriteRegister!=31, ReadDataN = WriteData in the same cycle.
//     - This removes the need for WB->ID forwarding in the hazard unit.
//     - Bypass is suppressed while reset=1, so the read shows the stored value.
//   REGFILE_BYPASS_EN undefined:
//     - ReadDataN shows the stored (old) value until the write edge; the new value appears after the edge.
//     - The hazard/forwarding unit must cover WB->ID.
// TESTING
//   1. Reset: fill X0..X30 with 64'hA5A5..., assert reset one edge
//      -> all 32 indices read 64'h0 on both ports.
//   2. Write/read: write X5=64'h0123_4567_89AB_CDEF, read R1=5, R2=4
//      -> ReadData1=0123_4567_89AB_CDEF, ReadData2=0.
//   3. XZR: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF
//      -> read 31 returns 0 before and after the edge; X0..X30 unchanged.
//   4. Write-enable off: RegWrite=0, WriteRegister=7, WriteData=64'hDEAD
//      -> X7 keeps its prior value 64'h1111.
//   5. Same-cycle read/write of X9 (old 64'h1, new 64'h2):
//      -> with REGFILE_BYPASS_EN, ReadData1=2 before the edge;
//      -> without it, ReadData1=1 before the edge and 2 after.
//   6. Reset+write collision: reset=1, RegWrite=1, X3<=64'h77
//      -> X3 reads 0 after the edge; next cycle with reset=0 the write lands and X3 reads 64'h77.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x 64-bit LEGv8 register file: one synchronous write port, two combinational read ports.
// X31 is XZR. Optional write-through read bypass selected by `define REGFILE_BYPASS_EN.
module regfile_32x64 #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [4:0]        WriteRegister,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

   // Word seen by the read muxes for every index; the XZR slot is a constant.
   logic [DATA_W-1:0] words [NUM_REGS];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      if (g == ZERO_REG) begin : g_zero
         assign words[g] = '0;
      end else begin : g_flop
         logic              we;
         logic [DATA_W-1:0] q;

         // One decoder output per flop; index ZERO_REG has no storage to enable.
         assign we = RegWrite && (WriteRegister == IDX_W'(g));

         always_ff @(posedge clk) begin
            if (reset) begin
               q <= '0;
            end else if (we) begin
               q <= WriteData;
            end
         end

         assign words[g] = q;
      end
   end

   logic [DATA_W-1:0] stored1;
   logic [DATA_W-1:0] stored2;

   assign stored1 = words[ReadRegister1];
   assign stored2 = words[ReadRegister2];

`ifdef REGFILE_BYPASS_EN
   logic wr_live;
   logic hit1;
   logic hit2;

   // Reset suppresses the bypass so reads show what is actually held in the flops.
   assign wr_live = RegWrite && !reset && (WriteRegister != ZERO_IDX);
   assign hit1    = wr_live && (WriteRegister == ReadRegister1);
   assign hit2    = wr_live && (WriteRegister == ReadRegister2);

   assign ReadData1 = hit1 ? WriteData : stored1;
   assign ReadData2 = hit2 ? WriteData : stored2;
`else
   assign ReadData1 = stored1;
   assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64: array model checked every cycle plus literal expectations.
module tb_regfile_32x64;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;

   int tests;
   int fails;
   bit check_en;

   logic [63:0] model [32];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   regfile_32x64 dut (
      .clk          (clk),
      .reset        (reset),
      .RegWrite     (RegWrite),
      .WriteRegister(WriteRegister),
      .WriteData    (WriteData),
      .ReadRegister1(ReadRegister1),
      .ReadRegister2(ReadRegister2),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural read: XZR is zero, bypass forwards a live write to a non-zero index.
   function automatic logic [63:0] exp_read(input logic [4:0] idx);
      if (BYPASS && RegWrite && !reset && WriteRegister == idx && idx != 5'd31) return WriteData;
      if (idx == 5'd31) return 64'h0;
      return model[idx];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] <= 64'h0;
      end else if (RegWrite && WriteRegister != 5'd31) begin
         model[WriteRegister] <= WriteData;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_rd1", ReadData1, exp_read(ReadRegister1));
         chk("model_rd2", ReadData2, exp_read(ReadRegister2));
      end
   end

   task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
      reset         = rst;
      RegWrite      = we;
      WriteRegister = wr;
      WriteData     = wd;
      ReadRegister1 = r1;
      ReadRegister2 = r2;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      check_en = 1'b0;
      drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
      tick();
      check_en = 1'b1;

      // Reset clears a fully populated file.
      for (int i = 0; i < 31; i++) begin
         drive(1'b0, 1'b1, 5'(i), 64'hA5A5_A5A5_A5A5_A5A5, 5'(i), 5'((i + 1) % 32));
         tick();
      end
      drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd30);
      chk("fill_x0", ReadData1, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("fill_x30", ReadData2, 64'hA5A5_A5A5_A5A5_A5A5);
      tick();
      drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
      tick();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
         chk("reset_rd1", ReadData1, 64'h0);
         chk("reset_rd2", ReadData2, 64'h0);
         tick();
      end

      // Basic write then read.
      drive(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd5, 5'd4);
      tick();
      drive(1'b0, 1'b0, 5'd5, 64'h0, 5'd5, 5'd4);
      chk("wr_x5", ReadData1, 64'h0123_4567_89AB_CDEF);
      chk("rd_x4", ReadData2, 64'h0);
      tick();

      // Writes to XZR are dropped.
      drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5);
      chk("xzr_before", ReadData1, 64'h0);
      tick();
      drive(1'b0, 1'b0, 5'd31, 64'h0, 5'd31, 5'd5);
      chk("xzr_after", ReadData1, 64'h0);
      chk("xzr_x5_kept", ReadData2, 64'h0123_4567_89AB_CDEF);
      tick();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i));
         tick();
      end

      // Write enable low leaves the target alone.
      drive(1'b0, 1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
      tick();
      drive(1'b0, 1'b0, 5'd7, 64'hDEAD, 5'd7, 5'd0);
      tick();
      drive(1'b0, 1'b0, 5'd7, 64'hDEAD, 5'd7, 5'd7);
      chk("we_off_x7", ReadData1, 64'h1111);
      tick();

      // Same-cycle read/write of X9 on both ports.
      drive(1'b0, 1'b1, 5'd9, 64'h1, 5'd0, 5'd0);
      tick();
      drive(1'b0, 1'b1, 5'd9, 64'h2, 5'd9, 5'd9);
      chk("rw_same_rd1", ReadData1, BYPASS ? 64'h2 : 64'h1);
      chk("rw_same_rd2", ReadData2, BYPASS ? 64'h2 : 64'h1);
      tick();
      drive(1'b0, 1'b0, 5'd9, 64'h0, 5'd9, 5'd7);
      chk("rw_after", ReadData1, 64'h2);
      tick();

      // Reset wins over a simultaneous write; the held write lands next cycle.
      drive(1'b0, 1'b1, 5'd3, 64'h55, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b1, 5'd3, 64'h77, 5'd3, 5'd9);
      chk("rst_col_before", ReadData1, 64'h55);
      tick();
      drive(1'b0, 1'b1, 5'd3, 64'h77, 5'd3, 5'd9);
      chk("rst_col_after", ReadData1, BYPASS ? 64'h77 : 64'h0);
      chk("rst_col_x9", ReadData2, 64'h0);
      tick();
      drive(1'b0, 1'b0, 5'd3, 64'h0, 5'd3, 5'd7);
      chk("rst_col_land", ReadData1, 64'h77);
      chk("rst_col_x7", ReadData2, 64'h0);
      tick();

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
